// File: rtl/puf_axil_pkg.sv
// rtl/puf_axil_pkg.sv - shared constants and FSM state types for the PUF AXI-Lite register block
package puf_axil_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CHAL = 2'd1;
  localparam logic [1:0] REG_RESP = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_START   = 0;
  localparam int CTRL_CLR     = 1;
  localparam int STAT_BUSY    = 0;
  localparam int STAT_DONE    = 1;
  localparam int STAT_OVERRUN = 2;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

endpackage

// File: rtl/axil_slave_if.sv
// rtl/axil_slave_if.sv - AXI4-Lite write/read channel FSMs presenting a simple register-port strobe interface
module axil_slave_if
  import puf_axil_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic                arvalid,
  output logic                arready,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rvalid,
  input  logic                rready,
  output logic                wr_en,
  output logic [1:0]          wr_idx,
  output logic [DATA_W-1:0]   wr_data,
  output logic [DATA_W/8-1:0] wr_strb,
  output logic                wr_err,
  output logic                rd_en,
  output logic [1:0]          rd_idx,
  input  logic [DATA_W-1:0]   rd_data
);

  wr_state_t wstate, wstate_n;
  rd_state_t rstate, rstate_n;
  logic live, aw_hs, w_hs, unused_ok;
  logic [1:0] aw_idx_q, bresp_q;
  logic [DATA_W-1:0] wdata_q, rdata_q;
  logic [DATA_W/8-1:0] wstrb_q;

  // live holds the readies low until the first edge after reset release
  assign awready = live && (wstate == W_IDLE || wstate == W_HAVE_W);
  assign wready  = live && (wstate == W_IDLE || wstate == W_HAVE_AW);
  assign bvalid  = (wstate == W_RESP);
  assign bresp   = bresp_q;
  assign arready = live && (rstate == R_IDLE);
  assign rvalid  = (rstate == R_DATA);
  assign rdata   = rdata_q;
  assign rresp   = RESP_OKAY;
  assign aw_hs   = awvalid && awready;
  assign w_hs    = wvalid && wready;
  assign rd_en   = arvalid && arready;
  assign rd_idx  = araddr[3:2];
  assign wr_err  = wr_idx[1];
  assign unused_ok = ^{awaddr, araddr};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate <= W_IDLE;
      rstate <= R_IDLE;
    end else begin
      wstate <= wstate_n;
      rstate <= rstate_n;
    end
  end

  always_comb begin
    wstate_n = wstate;
    wr_en    = 1'b0;
    wr_idx   = aw_idx_q;
    wr_data  = wdata_q;
    wr_strb  = wstrb_q;
    case (wstate)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_en    = 1'b1;
          wr_idx   = awaddr[3:2];
          wr_data  = wdata;
          wr_strb  = wstrb;
          wstate_n = W_RESP;
        end else if (aw_hs) begin
          wstate_n = W_HAVE_AW;
        end else if (w_hs) begin
          wstate_n = W_HAVE_W;
        end
      end
      W_HAVE_AW: begin
        if (w_hs) begin
          wr_en    = 1'b1;
          wr_data  = wdata;
          wr_strb  = wstrb;
          wstate_n = W_RESP;
        end
      end
      W_HAVE_W: begin
        if (aw_hs) begin
          wr_en    = 1'b1;
          wr_idx   = awaddr[3:2];
          wstate_n = W_RESP;
        end
      end
      W_RESP: if (bready) wstate_n = W_IDLE;
      default: wstate_n = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_n = rstate;
    case (rstate)
      R_IDLE:  if (rd_en) rstate_n = R_DATA;
      R_DATA:  if (rready) rstate_n = R_IDLE;
      default: rstate_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      live     <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      live <= 1'b1;
      if (wstate == W_IDLE && aw_hs && !w_hs) aw_idx_q <= awaddr[3:2];
      if (wstate == W_IDLE && w_hs && !aw_hs) begin
        wdata_q <= wdata;
        wstrb_q <= wstrb;
      end
      if (wr_en) bresp_q <= wr_err ? RESP_SLVERR : RESP_OKAY;
      if (rd_en) rdata_q <= rd_data;
    end
  end

endmodule

// File: rtl/puf_axil_slave.sv
// rtl/puf_axil_slave.sv - AXI4-Lite register block driving the arbiter PUF start/valid handshake
module puf_axil_slave
  import puf_axil_pkg::*;
#(
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int CHAL_W = 32,
  parameter int RESP_W = 1
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  output logic [CHAL_W-1:0]             puf_challenge,
  output logic                          puf_start,
  input  logic                          puf_valid,
  input  logic [RESP_W-1:0]             puf_response
);

  logic wr_en, wr_err, rd_en, ctrl_wr, unused_ok;
  logic [1:0] wr_idx, rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wr_data, rd_data;
  logic [3:0] wr_strb;
  logic [CHAL_W-1:0] chal_q, chal_n;
  logic [RESP_W-1:0] resp_q, resp_n;
  logic busy_q, done_q, ovr_q, start_q;
  logic busy_n, done_n, ovr_n, start_n;

  axil_slave_if #(.ADDR_W(C_S_AXI_ADDR_WIDTH), .DATA_W(C_S_AXI_DATA_WIDTH)) u_if (
    .clk(ACLK), .rst(ARESET),
    .awaddr(S_AXI_AWADDR), .awvalid(S_AXI_AWVALID), .awready(S_AXI_AWREADY),
    .wdata(S_AXI_WDATA), .wstrb(S_AXI_WSTRB), .wvalid(S_AXI_WVALID), .wready(S_AXI_WREADY),
    .bresp(S_AXI_BRESP), .bvalid(S_AXI_BVALID), .bready(S_AXI_BREADY),
    .araddr(S_AXI_ARADDR), .arvalid(S_AXI_ARVALID), .arready(S_AXI_ARREADY),
    .rdata(S_AXI_RDATA), .rresp(S_AXI_RRESP), .rvalid(S_AXI_RVALID), .rready(S_AXI_RREADY),
    .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data), .wr_strb(wr_strb), .wr_err(wr_err),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data)
  );

  assign puf_challenge = chal_q;
  assign puf_start     = start_q;
  assign ctrl_wr       = wr_en && !wr_err && (wr_idx == REG_CTRL) && wr_strb[0];
  assign unused_ok     = ^{S_AXI_AWPROT, S_AXI_ARPROT, rd_en, wr_data, wr_strb};

  always_comb begin
    chal_n = chal_q;
    if (wr_en && !wr_err && wr_idx == REG_CHAL)
      for (int i = 0; i < CHAL_W; i++)
        if (wr_strb[i/8]) chal_n[i] = wr_data[i];
  end

  // A completing response is absorbed before START is evaluated, so a
  // same-cycle START re-arms the core instead of flagging an overrun.
  always_comb begin
    resp_n  = resp_q;
    busy_n  = busy_q;
    done_n  = done_q;
    ovr_n   = ovr_q;
    start_n = 1'b0;
    if (puf_valid && busy_q) begin
      resp_n = puf_response;
      busy_n = 1'b0;
      done_n = 1'b1;
    end
    if (ctrl_wr) begin
      if (wr_data[CTRL_CLR]) begin
        done_n = 1'b0;
        ovr_n  = 1'b0;
      end
      if (wr_data[CTRL_START]) begin
        if (!busy_n) begin
          start_n = 1'b1;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end else begin
          ovr_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      chal_q  <= '0;
      resp_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
      start_q <= 1'b0;
    end else begin
      chal_q  <= chal_n;
      resp_q  <= resp_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      ovr_q   <= ovr_n;
      start_q <= start_n;
    end
  end

  always_comb begin
    rd_data = '0;
    case (rd_idx)
      REG_CHAL: rd_data[CHAL_W-1:0] = chal_q;
      REG_RESP: rd_data[RESP_W-1:0] = resp_q;
      REG_STAT: begin
        rd_data[STAT_BUSY]    = busy_q;
        rd_data[STAT_DONE]    = done_q;
        rd_data[STAT_OVERRUN] = ovr_q;
      end
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_puf_axil_slave.sv
// tb/tb_puf_axil_slave.sv - self-checking bench for puf_axil_slave: register table plus PUF handshake sequences
module tb_puf_axil_slave;

  logic        ACLK, ARESET;
  logic [3:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;
  logic [31:0] puf_challenge;
  logic        puf_start, puf_valid;
  logic [0:0]  puf_response;

  puf_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .puf_challenge(puf_challenge), .puf_start(puf_start),
    .puf_valid(puf_valid), .puf_response(puf_response)
  );

  typedef struct {
    bit          wr;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_dly;
    int          w_dly;
    int          b_dly;
    logic [31:0] exp;
  } vec_t;

  vec_t        vecs[$];
  logic [1:0]  bq[$];
  logic [31:0] rq[$];
  int checks = 0, failures = 0, start_cnt = 0, cnt0;

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  always @(negedge ACLK) if (puf_start === 1'b1) start_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout expected=handshake", name);
  endtask

  task automatic add_vec(input bit wr, input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int awd, input int wd, input int bd, input logic [31:0] e);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.aw_dly = awd; v.w_dly = wd; v.b_dly = bd; v.exp = e;
    vecs.push_back(v);
  endtask

  // called and returns at a falling edge; readies depend only on DUT state
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int aw_dly, input int w_dly, input int b_dly, input logic [1:0] exp);
    bit aw_done = 0, w_done = 0, aw_f, w_f;
    int n;
    logic [1:0] e;
    bq.push_back(exp);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    for (n = 0; n < 40 && !(aw_done && w_done); n++) begin
      S_AXI_AWVALID = !aw_done && n >= aw_dly;
      S_AXI_WVALID  = !w_done && n >= w_dly;
      aw_f = S_AXI_AWVALID && S_AXI_AWREADY;
      w_f  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge ACLK);
      aw_done |= aw_f;
      w_done  |= w_f;
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    e = bq.pop_front();
    if (!(aw_done && w_done)) begin
      fail($sformatf("wr_handshake@%h", addr));
    end else begin
      check($sformatf("bvalid_latency@%h", addr), S_AXI_BVALID, 1);
      for (n = 0; n < 20 && !S_AXI_BVALID; n++) @(negedge ACLK);
      for (int i = 0; i < b_dly; i++) begin
        check("bvalid_hold", S_AXI_BVALID, 1);
        check("awready_blocked", S_AXI_AWREADY, 0);
        @(negedge ACLK);
      end
      S_AXI_BREADY = 1'b1;
      check($sformatf("bresp@%h", addr), S_AXI_BRESP, e);
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
    end
  endtask

  task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
    bit f = 0;
    int n;
    logic [31:0] e;
    rq.push_back(exp);
    S_AXI_ARADDR = addr;
    for (n = 0; n < 40 && !f; n++) begin
      S_AXI_ARVALID = 1'b1;
      f = S_AXI_ARREADY;
      @(negedge ACLK);
    end
    S_AXI_ARVALID = 1'b0;
    e = rq.pop_front();
    if (!f) begin
      fail($sformatf("ar_handshake@%h", addr));
    end else begin
      check($sformatf("rvalid_latency@%h", addr), S_AXI_RVALID, 1);
      @(negedge ACLK);
      S_AXI_RREADY = 1'b1;
      check($sformatf("rvalid_hold@%h", addr), S_AXI_RVALID, 1);
      check($sformatf("rdata@%h", addr), S_AXI_RDATA, e);
      check($sformatf("rresp@%h", addr), S_AXI_RRESP, 0);
      @(negedge ACLK);
      S_AXI_RREADY = 1'b0;
    end
  endtask

  task automatic pulse_valid(input logic r);
    puf_response = r; puf_valid = 1'b1;
    @(negedge ACLK);
    puf_valid = 1'b0;
  endtask

  initial begin
    ARESET = 1'b1;
    S_AXI_AWADDR = 0; S_AXI_AWPROT = 0; S_AXI_AWVALID = 0;
    S_AXI_WDATA = 0; S_AXI_WSTRB = 0; S_AXI_WVALID = 0; S_AXI_BREADY = 0;
    S_AXI_ARADDR = 0; S_AXI_ARPROT = 0; S_AXI_ARVALID = 0; S_AXI_RREADY = 0;
    puf_valid = 0; puf_response = 0;

    add_vec(0, 4'h4, 0, 0, 0, 0, 0, 32'h0);
    add_vec(0, 4'h8, 0, 0, 0, 0, 0, 32'h0);
    add_vec(0, 4'hC, 0, 0, 0, 0, 0, 32'h0);
    add_vec(0, 4'h0, 0, 0, 0, 0, 0, 32'h0);
    add_vec(1, 4'h4, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 32'h0);
    add_vec(1, 4'h4, 32'h0000FF00, 4'h2, 0, 2, 0, 32'h0);
    add_vec(0, 4'h4, 0, 0, 0, 0, 0, 32'hA5A5FFA5);
    add_vec(0, 4'h7, 0, 0, 0, 0, 0, 32'hA5A5FFA5);
    add_vec(1, 4'h8, 32'hDEADBEEF, 4'hF, 3, 0, 0, 32'h2);
    add_vec(0, 4'h8, 0, 0, 0, 0, 0, 32'h0);
    add_vec(1, 4'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 1, 32'h2);
    add_vec(0, 4'hC, 0, 0, 0, 0, 0, 32'h0);
    add_vec(0, 4'h0, 0, 0, 0, 0, 0, 32'h0);
    add_vec(1, 4'h4, 32'h5A5A1234, 4'hC, 0, 0, 5, 32'h0);
    add_vec(0, 4'h4, 0, 0, 0, 0, 0, 32'h5A5AFFA5);

    repeat (2) @(negedge ACLK);
    check("rst_awready", S_AXI_AWREADY, 0);
    check("rst_arready", S_AXI_ARREADY, 0);
    check("rst_bvalid", S_AXI_BVALID, 0);
    check("rst_rvalid", S_AXI_RVALID, 0);
    check("rst_rdata", S_AXI_RDATA, 0);
    check("rst_start", puf_start, 0);
    ARESET = 1'b0;
    check("release_wready_low", S_AXI_WREADY, 0);
    @(negedge ACLK);
    check("release_ready", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 3'b111);

    foreach (vecs[k]) begin
      if (vecs[k].wr)
        axi_write(vecs[k].addr, vecs[k].data, vecs[k].strb, vecs[k].aw_dly,
                  vecs[k].w_dly, vecs[k].b_dly, vecs[k].exp[1:0]);
      else
        axi_read(vecs[k].addr, vecs[k].exp);
    end
    check("puf_challenge", puf_challenge, 32'h5A5AFFA5);

    // simultaneous read and write of CHALLENGE returns the old value
    S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h0; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    S_AXI_ARVALID = 0; S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
    check("collide_rvalid", S_AXI_RVALID, 1);
    check("collide_rdata_old", S_AXI_RDATA, 32'h5A5AFFA5);
    check("collide_bvalid", S_AXI_BVALID, 1);
    S_AXI_RREADY = 1; S_AXI_BREADY = 1;
    @(negedge ACLK);
    S_AXI_RREADY = 0; S_AXI_BREADY = 0;
    axi_read(4'h4, 32'h0);

    cnt0 = start_cnt;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, 2'b00);
    axi_read(4'hC, 32'h1);
    check("start_single_pulse", start_cnt, cnt0 + 1);
    repeat (20) @(negedge ACLK);
    pulse_valid(1'b1);
    axi_read(4'hC, 32'h2);
    axi_read(4'h8, 32'h1);

    cnt0 = start_cnt;
    axi_write(4'h0, 32'h1, 4'hF, 0, 0, 0, 2'b00);
    axi_write(4'h0, 32'h1, 4'hF, 1, 0, 0, 2'b00);
    axi_read(4'hC, 32'h5);
    check("overrun_one_pulse", start_cnt, cnt0 + 1);
    axi_write(4'h0, 32'h2, 4'hF, 0, 0, 0, 2'b00);
    axi_read(4'hC, 32'h1);

    pulse_valid(1'b0);
    axi_read(4'h8, 32'h0);
    axi_read(4'hC, 32'h2);
    pulse_valid(1'b1);
    axi_read(4'h8, 32'h0);
    cnt0 = start_cnt;
    axi_write(4'h0, 32'h1, 4'hE, 0, 0, 0, 2'b00);
    axi_read(4'hC, 32'h2);
    check("no_start_without_strb0", start_cnt, cnt0);

    axi_write(4'h0, 32'h3, 4'hF, 0, 0, 0, 2'b00);
    axi_read(4'hC, 32'h1);

    // START commit lands on the same edge as puf_valid
    cnt0 = start_cnt;
    S_AXI_AWADDR = 4'h0; S_AXI_WDATA = 32'h1; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1; S_AXI_WVALID = 1; puf_valid = 1; puf_response = 1'b1;
    @(negedge ACLK);
    S_AXI_AWVALID = 0; S_AXI_WVALID = 0; puf_valid = 0;
    check("collision_start_now", puf_start, 1);
    check("collision_bvalid", S_AXI_BVALID, 1);
    check("collision_bresp", S_AXI_BRESP, 2'b00);
    S_AXI_BREADY = 1;
    @(negedge ACLK);
    S_AXI_BREADY = 0;
    check("collision_start_gone", puf_start, 0);
    axi_read(4'h8, 32'h1);
    axi_read(4'hC, 32'h1);
    check("collision_one_pulse", start_cnt, cnt0 + 1);

    S_AXI_ARADDR = 4'hC; S_AXI_ARVALID = 1;
    @(negedge ACLK);
    S_AXI_ARVALID = 0;
    check("pre_reset_rvalid", S_AXI_RVALID, 1);
    ARESET = 1'b1;
    #1;
    check("reset_drops_rvalid", S_AXI_RVALID, 0);
    check("reset_arready", S_AXI_ARREADY, 0);
    @(negedge ACLK);
    ARESET = 1'b0;
    @(negedge ACLK);
    axi_read(4'hC, 32'h0);
    axi_read(4'h8, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/puf_axil_slave.md
Name: puf_axil_slave

Overview:
AXI4-Lite slave register block that fronts the arbiter PUF core. Software writes a challenge, pulses START, polls STATUS and reads the latched response. It sits between the AXI interconnect (driven by the master VIP in simulation) and the PUF core's start/valid handshake.

Parameters:
C_S_AXI_ADDR_WIDTH, 4, byte-address width; only bits [3:2] are decoded, the rest are ignored.
C_S_AXI_DATA_WIDTH, 32, data width; fixed at 32.
CHAL_W, 32, challenge width (1..32); the register holds CHAL_W bits, upper bits read 0.
RESP_W, 1, PUF response width (1..32); zero-extended on read.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in/out  1  AW handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in/out  1  W handshake
S_AXI_BRESP  out  2  00 OKAY, 10 SLVERR
S_AXI_BVALID / S_AXI_BREADY  out/in  1  B handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in/out  1  AR handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  always 00
S_AXI_RVALID / S_AXI_RREADY  out/in  1  R handshake
puf_challenge  out  CHAL_W  challenge to the PUF core
puf_start  out  1  one-cycle start pulse
puf_valid  in  1  one-cycle pulse: puf_response is valid
puf_response  in  RESP_W  PUF response

Behaviour:
- Reset (async assert, sync release): all readies 0, BVALID/RVALID 0, RDATA 0, BRESP 0, registers 0, puf_start 0. Readies rise on the first clock edge after release.
- Register map:
  - 0x0 CTRL (write-only, reads 0): bit0 START, bit1 CLR.
  - 0x4 CHALLENGE: read/write, honours WSTRB.
  - 0x8 RESPONSE: read-only; a write returns SLVERR and has no effect.
  - 0xC STATUS: read-only (bit0 BUSY, bit1 DONE, bit2 OVERRUN); a write returns SLVERR.
- Write FSM states: W_IDLE (AWREADY=1, WREADY=1), W_HAVE_AW (WREADY=1 only), W_HAVE_W (AWREADY=1 only), W_RESP (BVALID=1).
  - AW and W are accepted in any order, or in the same cycle.
  - The write commits on the clock edge that completes the pair. BVALID is asserted the next cycle and held until BREADY. Then the FSM returns to W_IDLE.
  - One write is outstanding at a time.
- Read FSM states: R_IDLE (ARREADY=1), R_DATA (RVALID=1).
  - The address is decoded at the AR handshake. RDATA is registered, so RVALID appears one cycle after the handshake. RDATA is held stable until RREADY.
- Simultaneous read and write to the same register: the read returns the pre-write value.
- CTRL write with WSTRB[0]=1:
  - CLR=1 clears DONE and OVERRUN.
  - START=1 while BUSY=0: puf_start pulses high for exactly one cycle on the cycle after commit; BUSY is set and DONE is cleared.
  - START=1 while BUSY=1: no pulse; OVERRUN is set.
  - START and CLR together: CLR applies first, then START.
- puf_valid while BUSY=1:
  - RESPONSE captures puf_response.
  - BUSY clears and DONE sets.
- puf_valid while BUSY=0: ignored, and RESPONSE is unchanged.
- puf_valid in the same cycle as a START commit: the response is captured first, then START applies. The end state is BUSY=1, DONE=0.
- puf_challenge is driven continuously from the CHALLENGE register. Software changing it while BUSY is allowed and not guarded.
- ARESET mid-transaction: both FSMs go to idle and any in-flight B/R beat is dropped. BUSY clears.

Decomposition:
- Package puf_axil_pkg:
  - register offset constants (CTRL=0, CHAL=1, RESP=2, STAT=3 as word index);
  - CTRL/STATUS bit-position constants;
  - RESP_OKAY and RESP_SLVERR constants;
  - write-FSM and read-FSM state enum typedefs.
- One sub-module, axil_slave_if: contains both channel FSMs. It exposes the following to the register logic in the top:
  - wr_en, wr_idx, wr_data, wr_strb, wr_err;
  - rd_en, rd_idx, rd_data.

Test Plan:
- Reset/readback: deassert ARESET → AW/W/AR readies go to 1 within one cycle; read 0x4, 0x8, 0xC → 0x00000000, RRESP=00.
- CHALLENGE with strobes: write 0x4 = 0xA5A5A5A5 with WSTRB=1111, then write 0x4 = 0x0000FF00 with WSTRB=0010; read 0x4 → 0xA5A5FFA5; puf_challenge matches.
- Start/complete: write CTRL=0x1 → puf_start is high for exactly 1 cycle, STATUS=0x1. Drive puf_valid with puf_response=1 after 20 cycles → STATUS=0x2, RESPONSE=0x00000001.
- Overrun and clear: START, then START again before puf_valid → a single puf_start pulse, STATUS=0x5. Write CTRL=0x2 → STATUS=0x1.
- RO write error and ordering: write 0x8 with W presented 3 cycles before AW → BRESP=10, RESPONSE unchanged. Write 0x4 with AW and W in the same cycle and BREADY held low 5 cycles → BVALID stays high; no second AW accepted until B completes.
- Collision: START commit in the same cycle as puf_valid (response=1) → RESPONSE=1, STATUS=0x1, one puf_start pulse. Assert ARESET while RVALID is pending → RVALID drops to 0 immediately.
